// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes and status/cause bit positions.
package cp0_defs;

    localparam logic [4:0] COUNT   = 5'd9;
    localparam logic [4:0] COMPARE = 5'd11;
    localparam logic [4:0] SR      = 5'd12;
    localparam logic [4:0] CAUSE   = 5'd13;
    localparam logic [4:0] EPC     = 5'd14;
    localparam logic [4:0] PRID    = 5'd15;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    localparam int unsigned IM_HI = 15;
    localparam int unsigned IM_LO = 10;
    localparam int unsigned EXL   = 1;
    localparam int unsigned IE    = 0;
    localparam int unsigned BD    = 31;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage <-> CP0 signal bundle: mfc0/mtc0 access, exception/interrupt inputs, flush request.
interface cp0_unit_if;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        exl_clr;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;

    modport master (
        output we, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, exl_clr, hw_int,
        input  cp0_out, req, epc_out
    );

    modport slave (
        input  we, cp0_addr, cp0_in, vpc, bd_in, exc_code_in, exl_clr, hw_int,
        output cp0_out, req, epc_out
    );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer: free-running Count, Compare match latches a pending tick.
module cp0_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        tick_pend
);

    logic [31:0] count_q;
    logic [31:0] compare_q;
    logic        tick_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            tick_q    <= 1'b0;
        end else begin
            count_q <= we_count ? wdata : count_q + 32'd1;
            if (we_compare) begin
                compare_q <= wdata;
            end
            // A Compare write acknowledges the tick and beats a same-cycle match
            if (we_compare) begin
                tick_q <= 1'b0;
            end else if (count_q == compare_q) begin
                tick_q <= 1'b1;
            end
        end
    end

    assign count     = count_q;
    assign compare   = compare_q;
    assign tick_pend = tick_q;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0 for the M stage: SR/Cause/EPC, interrupt/exception request and mfc0 read mux.
module cp0_unit
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL = 32'h0000_00C7,
    parameter bit          TIMER_EN = 1'b1
) (
    input logic       clk,
    input logic       reset,
    cp0_unit_if.slave bus
);

    logic [5:0]  sr_im_q;
    logic        sr_exl_q;
    logic        sr_ie_q;
    logic        cause_bd_q;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q;
    logic [31:0] epc_q;

    logic [31:0] count;
    logic [31:0] compare;
    logic        tick_pend;

    logic [5:0]  eff_int;
    logic        int_req;
    logic        exc_req;
    logic        take;
    logic        wr;

    assign eff_int = bus.hw_int | {tick_pend & TIMER_EN, 5'b0};
    assign int_req = (|(eff_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
    assign exc_req = (|bus.exc_code_in) & ~sr_exl_q;
    assign take    = ~reset & (int_req | exc_req);
    // Exception entry swallows any mtc0 in the same cycle
    assign wr      = bus.we & ~take;

    cp0_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .we_count   (wr && bus.cp0_addr == COUNT),
        .we_compare (wr && bus.cp0_addr == COMPARE),
        .wdata      (bus.cp0_in),
        .count      (count),
        .compare    (compare),
        .tick_pend  (tick_pend)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im_q     <= 6'd0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= 6'd0;
            cause_exc_q <= 5'd0;
            epc_q       <= 32'd0;
        end else begin
            cause_ip_q <= eff_int;
            if (take) begin
                sr_exl_q    <= 1'b1;
                cause_bd_q  <= bus.bd_in;
                cause_exc_q <= int_req ? EXC_INT : bus.exc_code_in;
                epc_q       <= word_align(bus.bd_in ? bus.vpc - 32'd4 : bus.vpc);
            end else begin
                if (wr && bus.cp0_addr == SR) begin
                    sr_im_q  <= bus.cp0_in[IM_HI:IM_LO];
                    sr_exl_q <= bus.cp0_in[EXL];
                    sr_ie_q  <= bus.cp0_in[IE];
                end
                if (bus.exl_clr) begin
                    sr_exl_q <= 1'b0;
                end
                if (wr && bus.cp0_addr == EPC) begin
                    epc_q <= word_align(bus.cp0_in);
                end
            end
        end
    end

    always_comb begin
        bus.cp0_out = 32'd0;
        case (bus.cp0_addr)
            SR:      bus.cp0_out = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
            CAUSE:   bus.cp0_out = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'b00};
            EPC:     bus.cp0_out = epc_q;
            PRID:    bus.cp0_out = PRID_VAL;
            COUNT:   bus.cp0_out = TIMER_EN ? count : 32'd0;
            COMPARE: bus.cp0_out = TIMER_EN ? compare : 32'd0;
            default: bus.cp0_out = 32'd0;
        endcase
    end

    // Forward a same-cycle mtc0 EPC so an eret behind it sees the new target
    assign bus.epc_out = (bus.we && bus.cp0_addr == EPC) ? word_align(bus.cp0_in) : epc_q;
    assign bus.req     = take;

endmodule

// File: tb/tb_cp0_unit.sv
// Self-checking bench for cp0_unit: directed scenarios plus randomized traffic vs a register model.
module tb_cp0_unit;
    import cp0_defs::*;

    localparam logic [31:0] PRID_C = 32'h0000_00C7;

    logic clk = 1'b0;
    logic reset;
    always #10 clk = ~clk;

    cp0_unit_if bus ();

    cp0_unit #(
        .PRID_VAL (PRID_C),
        .TIMER_EN (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model of CP0 state
    logic [31:0] m_count = 0, m_compare = 0, m_epc = 0;
    logic [5:0]  m_im = 0, m_ip = 0;
    logic        m_exl = 0, m_ie = 0, m_bd = 0, m_tick = 0;
    logic [4:0]  m_exc = 0;

    function automatic logic [5:0] m_eff();
        return bus.hw_int | (m_tick ? 6'b100000 : 6'b000000);
    endfunction

    function automatic logic m_irq();
        return ((m_eff() & m_im) != 6'd0) && m_ie && !m_exl;
    endfunction

    function automatic logic m_take();
        return !reset && (m_irq() || (bus.exc_code_in != 5'd0 && !m_exl));
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
            5'd13:   return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_exc) << 2);
            5'd14:   return m_epc;
            5'd15:   return PRID_C;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_count <= 0; m_compare <= 0; m_epc <= 0; m_im <= 0; m_ip <= 0;
            m_exl <= 0; m_ie <= 0; m_bd <= 0; m_tick <= 0; m_exc <= 0;
        end else begin
            m_ip <= m_eff();
            if (m_take()) begin
                m_exl <= 1'b1;
                m_bd  <= bus.bd_in;
                m_exc <= m_irq() ? 5'd0 : bus.exc_code_in;
                m_epc <= (bus.bd_in ? bus.vpc - 32'd4 : bus.vpc) & ~32'd3;
            end else begin
                if (bus.we && bus.cp0_addr == 5'd12) begin
                    m_im  <= bus.cp0_in[15:10];
                    m_exl <= bus.cp0_in[1];
                    m_ie  <= bus.cp0_in[0];
                end
                if (bus.exl_clr) m_exl <= 1'b0;
                if (bus.we && bus.cp0_addr == 5'd14) m_epc <= bus.cp0_in & ~32'd3;
            end
            if (!m_take() && bus.we && bus.cp0_addr == 5'd9) m_count <= bus.cp0_in;
            else m_count <= m_count + 32'd1;
            if (!m_take() && bus.we && bus.cp0_addr == 5'd11) begin
                m_compare <= bus.cp0_in;
                m_tick    <= 1'b0;
            end else if (m_count == m_compare) begin
                m_tick <= 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        check("req", 32'(bus.req), 32'(m_take()));
        check("cp0_out", bus.cp0_out, m_read(bus.cp0_addr));
        check("epc_out", bus.epc_out,
              (bus.we && bus.cp0_addr == 5'd14) ? (bus.cp0_in & ~32'd3) : m_epc);
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        bus.we = 1'b1; bus.cp0_addr = a; bus.cp0_in = d;
        next();
        bus.we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [4:0] a, input logic [31:0] exp);
        bus.cp0_addr = a;
        #1;
        check(name, bus.cp0_out, exp);
    endtask

    initial begin
        reset = 1'b1;
        bus.we = 0; bus.cp0_addr = 0; bus.cp0_in = 0; bus.vpc = 0; bus.bd_in = 0;
        bus.exc_code_in = 0; bus.exl_clr = 0; bus.hw_int = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cp0_out", bus.cp0_out, 32'd0);
        check("reset_req", 32'(bus.req), 32'd0);
        reset = 1'b0;

        rd("rst_count", 5'd9, 32'd0);
        rd("rst_compare", 5'd11, 32'd0);
        rd("rst_sr", 5'd12, 32'd0);
        rd("rst_cause", 5'd13, 32'd0);
        rd("rst_epc", 5'd14, 32'd0);
        rd("rst_prid", 5'd15, PRID_C);
        rd("unmapped", 5'd7, 32'd0);
        check("rst_epc_out", bus.epc_out, 32'd0);
        mtc0(5'd11, 32'hFFFF_0000);

        // Interrupt on HW0
        mtc0(5'd12, 32'h0000_0401);
        bus.hw_int = 6'b000001; bus.vpc = 32'h0000_1000; bus.cp0_addr = 5'd13;
        #1;
        check("int_req", 32'(bus.req), 32'd1);
        next();
        rd("int_cause", 5'd13, 32'h0000_0400);
        rd("int_sr_exl", 5'd12, 32'h0000_0403);
        rd("int_epc", 5'd14, 32'h0000_1000);
        check("exl_blocks_req", 32'(bus.req), 32'd0);
        bus.hw_int = 0; bus.exl_clr = 1;
        next();
        bus.exl_clr = 0;
        rd("eret_sr", 5'd12, 32'h0000_0401);

        // Overflow in a delay slot, concurrent mtc0 EPC dropped
        bus.exc_code_in = EXC_OV; bus.bd_in = 1; bus.vpc = 32'h0000_3010;
        bus.we = 1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'hDEAD_BEEF;
        #1;
        check("exc_req", 32'(bus.req), 32'd1);
        next();
        bus.we = 0; bus.exc_code_in = 0; bus.bd_in = 0;
        rd("ov_cause", 5'd13, 32'h8000_0030);
        rd("ov_epc", 5'd14, 32'h0000_300C);
        bus.exl_clr = 1;
        next();
        bus.exl_clr = 0;

        // Interrupt beats exception
        mtc0(5'd12, 32'h0000_1001);
        bus.hw_int = 6'b000100; bus.exc_code_in = EXC_RI;
        #1;
        check("both_req", 32'(bus.req), 32'd1);
        next();
        bus.hw_int = 0; bus.exc_code_in = 0;
        rd("both_cause", 5'd13, 32'h0000_1000);
        check("both_exccode", 32'(bus.cp0_out[6:2]), 32'd0);

        // eret with same-cycle mtc0 EPC
        bus.we = 1; bus.cp0_addr = 5'd14; bus.cp0_in = 32'h0000_4007; bus.exl_clr = 1;
        #1;
        check("epc_fwd", bus.epc_out, 32'h0000_4004);
        next();
        bus.we = 0; bus.exl_clr = 0;
        rd("fwd_sr", 5'd12, 32'h0000_1001);
        rd("fwd_epc", 5'd14, 32'h0000_4004);

        // Timer wrap and tick
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'h0000_0000);
        mtc0(5'd9, 32'hFFFF_FFFE);
        rd("cnt_fffe", 5'd9, 32'hFFFF_FFFE);
        next();
        rd("cnt_ffff", 5'd9, 32'hFFFF_FFFF);
        next();
        rd("cnt_wrap", 5'd9, 32'd0);
        check("no_tick_yet", 32'(bus.req), 32'd0);
        next();
        check("timer_req", 32'(bus.req), 32'd1);
        next();
        rd("timer_cause", 5'd13, 32'h0000_8000);
        mtc0(5'd11, 32'h8000_0000);
        rd("timer_cause_lag", 5'd13, 32'h0000_8000);
        bus.exl_clr = 1;
        next();
        bus.exl_clr = 0;
        rd("tick_cleared_cause", 5'd13, 32'd0);
        check("tick_cleared_req", 32'(bus.req), 32'd0);

        // Reset mid-handler
        bus.exc_code_in = EXC_ADEL; bus.vpc = 32'h0000_5000;
        next();
        bus.exc_code_in = 0;
        rd("pre_reset_sr", 5'd12, 32'h0000_8003);
        reset = 1;
        next();
        next();
        reset = 0;
        rd("post_sr", 5'd12, 32'd0);
        rd("post_cause", 5'd13, 32'd0);
        rd("post_epc", 5'd14, 32'd0);
        rd("post_count", 5'd9, 32'd0);
        rd("post_compare", 5'd11, 32'd0);
        check("post_req", 32'(bus.req), 32'd0);

        // Randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            next();
            reset = ($urandom_range(0, 199) == 0);
            bus.we = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0: bus.cp0_addr = 5'd9;
                1: bus.cp0_addr = 5'd11;
                2: bus.cp0_addr = 5'd12;
                3: bus.cp0_addr = 5'd13;
                4: bus.cp0_addr = 5'd14;
                5: bus.cp0_addr = 5'd15;
                6: bus.cp0_addr = 5'd7;
                default: bus.cp0_addr = 5'($urandom);
            endcase
            bus.cp0_in = $urandom;
            if (bus.we && bus.cp0_addr == 5'd9 && $urandom_range(0, 1) == 0)
                bus.cp0_in = m_compare - 32'($urandom_range(1, 4));
            bus.vpc = $urandom;
            bus.bd_in = 1'($urandom);
            case ($urandom_range(0, 15))
                0: bus.exc_code_in = EXC_ADEL;
                1: bus.exc_code_in = EXC_ADES;
                2: bus.exc_code_in = EXC_RI;
                3: bus.exc_code_in = EXC_OV;
                default: bus.exc_code_in = 5'd0;
            endcase
            bus.exl_clr = ($urandom_range(0, 5) == 0) && !(bus.we && bus.cp0_addr == 5'd12);
            bus.hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
        end
        next();
        reset = 1;
        next();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
